// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the single register-file write port between the
// pipeline W stage and a multi-cycle divider.
//
// Divider results wait in a 2-entry FIFO. The W stage normally wins the port.
// A starvation counter forces a FIFO drain (wb_hold) after seven consecutive
// cycles in which the pipeline wrote while a result waited. A pending
// scoreboard tracks registers that still await a divider result and raises
// stall for D-stage readers of those registers.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   pipe_we/a3/wd         W-stage write request
//   div_valid/a3/wd       divider result; div_ready = FIFO has room
//   iss_valid/a3          divider op issued (marks destination pending)
//   rs_addr, rt_addr      D-stage sources checked against the scoreboard
//   stall                 a D-stage source awaits a divider result
//   wb_hold               W stage must freeze; port goes to the FIFO
//   grf_we/a3/wd          register-file write port
module grf_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic        div_valid,
    input  logic [4:0]  div_a3,
    input  logic [31:0] div_wd,
    output logic        div_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_a3,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        stall,
    output logic        wb_hold,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd
);

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FIFO = 2'd2
    } grant_e;

    logic [1:0][4:0]  fifo_a3_q, fifo_a3_d;
    logic [1:0][31:0] fifo_wd_q, fifo_wd_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [2:0]       starve_q, starve_d;
    logic [31:0]      pending_q, pending_d;

    logic             fifo_empty_s;
    logic             pipe_eff_s;
    logic             push_s;
    logic             pop_s;
    logic [4:0]       head_a3_s;
    logic [31:0]      head_wd_s;
    grant_e           grant_s;

    // Port grant, write-port drive and status outputs from registered state.
    always_comb begin
        fifo_empty_s = (count_q == 2'd0);
        div_ready    = (count_q < 2'd2);
        head_a3_s    = fifo_a3_q[rd_ptr_q];
        head_wd_s    = fifo_wd_q[rd_ptr_q];
        wb_hold      = (starve_q == 3'd7) && !fifo_empty_s;
        pipe_eff_s   = pipe_we && (pipe_a3 != 5'd0);
        stall        = ((rs_addr != 5'd0) && pending_q[rs_addr]) ||
                       ((rt_addr != 5'd0) && pending_q[rt_addr]);

        // A reset cycle grants nobody so buffered results are never written.
        if (reset) begin
            grant_s = GNT_IDLE;
        end else if (wb_hold) begin
            grant_s = GNT_FIFO;
        end else if (pipe_eff_s) begin
            grant_s = GNT_PIPE;
        end else if (!fifo_empty_s) begin
            grant_s = GNT_FIFO;
        end else begin
            grant_s = GNT_IDLE;
        end

        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        case (grant_s)
            GNT_FIFO: begin
                grf_we = (head_a3_s != 5'd0);
                grf_a3 = head_a3_s;
                grf_wd = head_wd_s;
            end
            GNT_PIPE: begin
                grf_we = 1'b1;
                grf_a3 = pipe_a3;
                grf_wd = pipe_wd;
            end
            default: begin
                grf_we = 1'b0;
                grf_a3 = 5'd0;
                grf_wd = 32'd0;
            end
        endcase

        pop_s  = (grant_s == GNT_FIFO);
        push_s = div_valid && div_ready;
    end

    // Next-state for FIFO, starvation counter and pending scoreboard.
    always_comb begin
        fifo_a3_d = fifo_a3_q;
        fifo_wd_d = fifo_wd_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        pending_d = pending_q;

        if (push_s) begin
            fifo_a3_d[wr_ptr_q] = div_a3;
            fifo_wd_d[wr_ptr_q] = div_wd;
            wr_ptr_d            = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Counts cycles a waiting result lost the port to the pipeline.
        if (pop_s || fifo_empty_s) begin
            starve_d = 3'd0;
        end else if ((grant_s == GNT_PIPE) && (starve_q != 3'd7)) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = starve_q;
        end

        // Clear first so a same-cycle issue to the same register wins.
        if (pop_s && (head_a3_s != 5'd0)) begin
            pending_d[head_a3_s] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (iss_valid && (iss_a3 != 5'd0)) begin
            pending_d[iss_a3] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_a3_q <= '0;
            fifo_wd_q <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            starve_q  <= 3'd0;
            pending_q <= 32'd0;
        end else begin
            fifo_a3_q <= fifo_a3_d;
            fifo_wd_q <= fifo_wd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
    end

endmodule
